// File: rtl/trig_rb_pkg.sv
// Shared constants and FSM encoding for the triggered multi-channel ring buffer.
package trig_rb_pkg;

  localparam int NCH_DEF   = 4;
  localparam int SIZE_DEF  = 10;
  localparam int WIDTH_DEF = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_POST   = 3'd2,
    ST_FROZEN = 3'd3,
    ST_READ   = 3'd4
  } rb_state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module rb_dpram #(
  parameter int AW = 10,
  parameter int DW = 56
) (
  input  logic          sysclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // No reset on storage or read data so this maps onto block RAM.
  always_ff @(posedge sysclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trig_ringbuffer.sv
// Triggered ADC ring buffer: captures NCH channels per word around a trigger,
// then replays the whole buffer oldest-first, one channel per handshake.
module trig_ringbuffer
  import trig_rb_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int SIZE  = SIZE_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     wr_en,
  input  logic [NCH*WIDTH-1:0]     din,
  input  logic                     trig,
  input  logic [SIZE-1:0]          post_len,
  input  logic                     rd_start,
  output logic [WIDTH-1:0]         dout,
  output logic [ch_bits(NCH)-1:0]  dout_ch,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic [SIZE-1:0]          trig_addr,
  output logic [2:0]               state_o
);

  localparam int CHW = ch_bits(NCH);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  rb_state_t state_reg, state_next;

  logic [SIZE-1:0]      wptr_reg;
  logic [SIZE-1:0]      post_cnt_reg;
  logic                 pend_reg;      // trigger seen, trigger sample not yet written
  logic [SIZE-1:0]      rd_ptr_reg;    // next address to fetch; rdata holds rd_ptr_reg-1
  logic [CHW-1:0]       ch_idx_reg;
  logic                 word_v_reg;    // rdata holds a word not yet fully serialised

  logic                 we;
  logic                 trig_hit;
  logic                 post_done;
  logic                 xfer;
  logic                 load;
  logic                 ch_end;
  logic                 last_word;
  logic                 re;
  logic [SIZE-1:0]      raddr;
  logic [NCH*WIDTH-1:0] rdata;
  logic [WIDTH-1:0]     rd_ch [NCH];

  rb_dpram #(
    .AW (SIZE),
    .DW (NCH*WIDTH)
  ) u_ram (
    .sysclk (sysclk),
    .we     (we),
    .waddr  (wptr_reg),
    .wdata  (din),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign rd_ch[gi] = rdata[gi*WIDTH +: WIDTH];
  end

  assign we        = wr_en && ((state_reg == ST_ACQ) || (state_reg == ST_POST));
  assign trig_hit  = trig && (state_reg == ST_ACQ);
  assign post_done = wr_en && (pend_reg ? (post_cnt_reg == '0)
                                        : (post_cnt_reg == SIZE'(1)));
  assign xfer      = dout_valid && dout_ready;
  assign load      = (state_reg == ST_READ) && word_v_reg && (!dout_valid || dout_ready);
  assign ch_end    = (ch_idx_reg == CH_LAST);
  // Buffer is replayed once around; the word just before wptr is the final one.
  assign last_word = (rd_ptr_reg == wptr_reg);
  // Next word is fetched while its predecessor's last channel moves out.
  assign re        = ((state_reg == ST_FROZEN) && rd_start) || (load && ch_end && !last_word);
  assign raddr     = (state_reg == ST_FROZEN) ? wptr_reg : rd_ptr_reg;
  assign state_o   = state_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (arm) state_next = ST_ACQ;
      ST_ACQ:    if (trig) state_next = (wr_en && (post_len == '0)) ? ST_FROZEN : ST_POST;
      ST_POST:   if (post_done) state_next = ST_FROZEN;
      ST_FROZEN: if (rd_start) state_next = ST_READ;
      ST_READ:   if (xfer && dout_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wptr_reg     <= '0;
      post_cnt_reg <= '0;
      pend_reg     <= 1'b0;
      trig_addr    <= '0;
      rd_ptr_reg   <= '0;
      ch_idx_reg   <= '0;
      word_v_reg   <= 1'b0;
      dout         <= '0;
      dout_ch      <= '0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (we) wptr_reg <= wptr_reg + 1'b1;

      if (trig_hit) begin
        trig_addr    <= wptr_reg;
        post_cnt_reg <= post_len;
        pend_reg     <= !wr_en;
      end else if ((state_reg == ST_POST) && wr_en) begin
        if (pend_reg) pend_reg <= 1'b0;
        else          post_cnt_reg <= post_cnt_reg - 1'b1;
      end

      if ((state_reg == ST_FROZEN) && rd_start) begin
        rd_ptr_reg <= wptr_reg + 1'b1;
        ch_idx_reg <= '0;
        word_v_reg <= 1'b1;
      end else if (load) begin
        dout       <= rd_ch[ch_idx_reg];
        dout_ch    <= ch_idx_reg;
        dout_last  <= ch_end && last_word;
        dout_valid <= 1'b1;
        if (ch_end) begin
          ch_idx_reg <= '0;
          if (last_word) word_v_reg <= 1'b0;
          else           rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end else begin
          ch_idx_reg <= ch_idx_reg + 1'b1;
        end
      end else if (xfer) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trig_ringbuffer.sv
// Scoreboard bench for trig_ringbuffer with NCH=2, SIZE=4, WIDTH=14.
module tb_trig_ringbuffer;

  localparam int NCH   = 2;
  localparam int SIZE  = 4;
  localparam int WIDTH = 14;
  localparam int NW    = 16;

  logic                 sysclk = 1'b0;
  logic                 rst = 1'b0;
  logic                 arm = 1'b0;
  logic                 wr_en = 1'b0;
  logic [NCH*WIDTH-1:0] din = '0;
  logic                 trig = 1'b0;
  logic [SIZE-1:0]      post_len = '0;
  logic                 rd_start = 1'b0;
  logic [WIDTH-1:0]     dout;
  logic [0:0]           dout_ch;
  logic                 dout_valid;
  logic                 dout_ready = 1'b1;
  logic                 dout_last;
  logic [SIZE-1:0]      trig_addr;
  logic [2:0]           state_o;

  always #5 sysclk = ~sysclk;

  trig_ringbuffer #(.NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .arm        (arm),
    .wr_en      (wr_en),
    .din        (din),
    .trig       (trig),
    .post_len   (post_len),
    .rd_start   (rd_start),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .trig_addr  (trig_addr),
    .state_o    (state_o)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ch;
    logic             last;
    logic             known;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n_xfer = 0;
  int   sh_n [NW];
  bit   sh_k [NW];
  int   exp_wptr = 0;
  logic [7:0] lfsr = 8'h5b;

  bit               stall_prev = 1'b0;
  logic [WIDTH-1:0] h_dout;
  logic             h_ch;
  logic             h_last;

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge sysclk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests++;
        if (!dout_valid || dout !== h_dout || dout_ch !== h_ch || dout_last !== h_last) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b d=%0h ch=%0d last=%0b, required v=1 d=%0h ch=%0d last=%0b",
                   dout_valid, dout, dout_ch, dout_last, h_dout, h_ch, h_last);
        end
      end
      if (dout_valid && dout_ready) begin
        tests++;
        n_xfer++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_xfer: got d=%0h ch=%0d, required no transfer", dout, dout_ch);
        end else begin
          e = sb.pop_front();
          if (dout_ch !== e.ch || dout_last !== e.last || (e.known && dout !== e.data)) begin
            fails++;
            $display("FAIL xfer%0d: got d=%0h ch=%0d last=%0b, required d=%0h ch=%0d last=%0b",
                     n_xfer, dout, dout_ch, dout_last, e.data, e.ch, e.last);
          end
        end
      end
      stall_prev = dout_valid && !dout_ready;
      h_dout = dout;
      h_ch   = dout_ch;
      h_last = dout_last;
    end
  end

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; wr_en = 1'b0; trig = 1'b0; rd_start = 1'b0; dout_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    exp_wptr = 0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  // One input cycle; 'store' states whether the bench expects the write to land.
  task automatic step(input bit wr, input int n, input bit tr, input int pl, input bit store);
    wr_en    = wr;
    din      = {WIDTH'(256 + n), WIDTH'(n)};
    trig     = tr;
    post_len = SIZE'(pl);
    cyc();
    wr_en = 1'b0;
    trig  = 1'b0;
    if (wr && store) begin
      sh_n[exp_wptr] = n;
      sh_k[exp_wptr] = 1'b1;
      exp_wptr = (exp_wptr + 1) % NW;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      for (int c = 0; c < NCH; c++) begin
        int a;
        a = (exp_wptr + i) % NW;
        e.data  = WIDTH'(c * 256 + sh_n[a]);
        e.ch    = c[0];
        e.last  = (i == NW - 1) && (c == NCH - 1);
        e.known = sh_k[a];
        sb.push_back(e);
      end
    end
    n_xfer = 0;
  endtask

  // Readout with dout_ready held high: fixed latency, no bubbles.
  task automatic readout_fixed(input int exp_ta);
    push_exp();
    dout_ready = 1'b1;
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    check("valid_lat1", dout_valid, 0);
    cyc();
    check("valid_lat2", dout_valid, 1);
    trig = 1'b1; arm = 1'b1;
    cyc();
    trig = 1'b0; arm = 1'b0;
    check("read_ignore_state", state_o, 4);
    check("read_ignore_taddr", trig_addr, exp_ta);
    repeat (30) cyc();
    check("last_on_32nd", dout_last, 1);
    cyc();
    check("idle_after_read", state_o, 0);
    check("valid_after_read", dout_valid, 0);
    check("xfer_count", n_xfer, 32);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic readout_rand();
    int guard;
    push_exp();
    dout_ready = 1'b1;
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    cyc();
    check("rand_first_valid", dout_valid, 1);
    guard = 0;
    while (state_o != 3'd0 && guard < 400) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      dout_ready = lfsr[0];
      cyc();
      guard++;
    end
    dout_ready = 1'b1;
    check("rand_timeout", int'(guard < 400), 1);
    check("rand_xfer_count", n_xfer, 32);
    check("rand_sb_drained", sb.size(), 0);
  endtask

  task automatic readout_abort();
    int guard;
    push_exp();
    dout_ready = 1'b1;
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    guard = 0;
    while (n_xfer < 7 && guard < 100) begin
      cyc();
      guard++;
    end
    rst = 1'b1;
    #1;
    check("abort_valid", dout_valid, 0);
    check("abort_state", state_o, 0);
    check("abort_xfers", n_xfer, 7);
    sb.delete();
    cyc();
    rst = 1'b0;
    exp_wptr = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_state", state_o, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_last", dout_last, 0);
    check("rst_dout", dout, 0);
    check("rst_taddr", trig_addr, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // Basic capture: trigger on sample 10, post_len 3
    arm_pulse();
    check("t1_acq", state_o, 1);
    for (int n = 0; n < 10; n++) step(1'b1, n, 1'b0, 0, 1'b1);
    step(1'b1, 10, 1'b1, 3, 1'b1);
    check("t1_post", state_o, 2);
    check("t1_taddr", trig_addr, 10);
    step(1'b1, 11, 1'b0, 0, 1'b1);
    step(1'b1, 12, 1'b0, 0, 1'b1);
    check("t1_still_post", state_o, 2);
    step(1'b1, 13, 1'b0, 0, 1'b1);
    check("t1_frozen", state_o, 3);
    for (int n = 14; n <= 20; n++) step(1'b1, n, 1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1, 7, 1'b0);
    check("t1_trig_frozen_state", state_o, 3);
    check("t1_trig_frozen_taddr", trig_addr, 10);
    arm_pulse();
    check("t1_arm_frozen", state_o, 3);
    readout_fixed(10);
    step(1'b0, 0, 1'b1, 5, 1'b0);
    check("t1_trig_idle_state", state_o, 0);
    check("t1_trig_idle_taddr", trig_addr, 10);

    // Wrap-around: 40 writes, trigger on 40, post_len 5
    do_reset();
    check("t2_rst_taddr", trig_addr, 0);
    arm_pulse();
    arm_pulse();
    check("t2_arm_in_acq", state_o, 1);
    for (int n = 0; n < 40; n++) step(1'b1, n, 1'b0, 0, 1'b1);
    step(1'b1, 40, 1'b1, 5, 1'b1);
    check("t2_taddr", trig_addr, 8);
    check("t2_post", state_o, 2);
    for (int n = 41; n <= 45; n++) step(1'b1, n, 1'b0, 0, 1'b1);
    check("t2_frozen", state_o, 3);
    readout_fixed(8);

    // post_len = 0 with write on trigger, then backpressured readout
    do_reset();
    arm_pulse();
    for (int n = 0; n < 5; n++) step(1'b1, n, 1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1, 0, 1'b1);
    check("t3_direct_frozen", state_o, 3);
    check("t3_taddr", trig_addr, 5);
    step(1'b1, 6, 1'b0, 0, 1'b0);
    readout_rand();

    // Trigger without a write, then reset mid-readout and recapture
    do_reset();
    arm_pulse();
    for (int n = 0; n < 3; n++) step(1'b1, n, 1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1, 2, 1'b0);
    check("t4_post", state_o, 2);
    check("t4_taddr", trig_addr, 3);
    step(1'b1, 3, 1'b0, 0, 1'b1);
    step(1'b1, 4, 1'b0, 0, 1'b1);
    check("t4_still_post", state_o, 2);
    step(1'b1, 5, 1'b0, 0, 1'b1);
    check("t4_frozen", state_o, 3);
    readout_abort();
    arm_pulse();
    step(1'b1, 50, 1'b0, 0, 1'b1);
    step(1'b1, 51, 1'b0, 0, 1'b1);
    step(1'b1, 52, 1'b1, 1, 1'b1);
    check("t4b_taddr", trig_addr, 2);
    check("t4b_post", state_o, 2);
    step(1'b1, 53, 1'b0, 0, 1'b1);
    check("t4b_frozen", state_o, 3);
    readout_fixed(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
